// File: rtl/snake_position_updater.sv
// snake_position_updater: per-tick snake game step engine.
// Shifts the tail buffer, moves the head with wrap, checks self-collision, grows on apple.
module snake_position_updater #(
    parameter int GRID_WIDTH  = 40,
    parameter int GRID_HEIGHT = 30,
    parameter int MAX_TAILS   = 32,
    parameter int POS_W       = 12,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       direction,
    input  logic [POS_W-1:0] apple_pos,
    input  logic [CNT_W-1:0] value_addr,
    output logic [POS_W-1:0] cur_tail_pos,
    output logic [POS_W-1:0] snake_head_pos,
    output logic [CNT_W-1:0] num_tails,
    output logic             calculation_finished,
    output logic             apple_eaten,
    output logic             game_over,
    output logic             busy
);

    localparam int XW = $clog2(GRID_WIDTH);
    localparam int YW = $clog2(GRID_HEIGHT);
    localparam int IW = $clog2(MAX_TAILS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_MOVE  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [XW-1:0] X_RST = XW'(GRID_WIDTH / 2);
    localparam logic [YW-1:0] Y_RST = YW'(GRID_HEIGHT / 2);
    localparam logic [XW-1:0] X_MAX = XW'(GRID_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_HEIGHT - 1);
    localparam logic [POS_W-1:0] HEAD_RST =
        POS_W'((GRID_HEIGHT / 2) * GRID_WIDTH + GRID_WIDTH / 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TAILS);
    localparam logic [CNT_W-1:0] IDX_MAX  = CNT_W'(MAX_TAILS - 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [POS_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             eaten_q, eaten_d;
    logic             over_q, over_d;

    logic [POS_W-1:0] tail_q [MAX_TAILS];
    logic             tail_we;
    logic [IW-1:0]    tail_wa;
    logic [POS_W-1:0] tail_wd;

    logic [XW-1:0]    nx;
    logic [YW-1:0]    ny;
    logic [POS_W-1:0] new_pos;
    logic [IW-1:0]    prev_idx;
    logic [POS_W-1:0] chk_tail;
    logic             hit;
    logic             last_k;

    assign snake_head_pos       = head_q;
    assign num_tails            = num_q;
    assign calculation_finished = done_q;
    assign apple_eaten          = eaten_q;
    assign game_over            = over_q;
    assign busy                 = (state_q != S_IDLE);

    assign prev_idx = IW'(cnt_q - 1'b1);
    assign chk_tail = tail_q[cnt_q[IW-1:0]];
    assign hit      = (num_q != '0) && (head_q == chk_tail);
    assign last_k   = (num_q == '0) || (cnt_q == num_q - 1'b1);

    // Tail read port; out-of-range indices read as zero.
    always_comb begin
        cur_tail_pos = '0;
        if (value_addr < CNT_MAX)
            cur_tail_pos = tail_q[value_addr[IW-1:0]];
    end

    // Next head cell one step along the latched direction, wrapping at edges.
    always_comb begin
        nx = x_q;
        ny = y_q;
        case (dir_q)
            2'b00:   ny = (y_q == '0) ? Y_MAX : y_q - 1'b1;
            2'b01:   nx = (x_q == X_MAX) ? '0 : x_q + 1'b1;
            2'b10:   ny = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            default: nx = (x_q == '0) ? X_MAX : x_q - 1'b1;
        endcase
        new_pos = POS_W'(ny) * POS_W'(GRID_WIDTH) + POS_W'(nx);
    end

    // Step sequencer: IDLE -> SHIFT -> MOVE -> CHECK -> DONE.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        head_d  = head_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        over_d  = over_q;
        done_d  = 1'b0;
        eaten_d = 1'b0;
        tail_we = 1'b0;
        tail_wa = cnt_q[IW-1:0];
        tail_wd = tail_q[prev_idx];
        case (state_q)
            S_IDLE: begin
                if (tick && !over_q) begin
                    state_d = S_SHIFT;
                    if (!((direction == (dir_q ^ 2'b10)) && (num_q != '0)))
                        dir_d = direction;
                    cnt_d = (num_q >= IDX_MAX) ? IDX_MAX : num_q;
                end
            end
            S_SHIFT: begin
                tail_we = 1'b1;
                if (cnt_q == '0) begin
                    tail_wd = head_q;
                    state_d = S_MOVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MOVE: begin
                x_d     = nx;
                y_d     = ny;
                head_d  = new_pos;
                cnt_d   = '0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (hit)
                    over_d = 1'b1;
                if (last_k) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if ((head_q == apple_pos) && !(over_q || hit)) begin
                        eaten_d = 1'b1;
                        if (num_q < CNT_MAX)
                            num_d = num_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and head state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= 2'b01;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            head_q  <= HEAD_RST;
            num_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            eaten_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            head_q  <= head_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            eaten_q <= eaten_d;
            over_q  <= over_d;
        end
    end

    // Tail buffer: one entry written per SHIFT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_TAILS; i++)
                tail_q[i] <= '0;
        end else if (tail_we) begin
            tail_q[tail_wa] <= tail_wd;
        end
    end

endmodule

// File: tb/tb_snake_position_updater.sv
// tb_snake_position_updater: directed checks of snake_position_updater.
// Hand-computed heads, latencies, tail contents and collision outcomes.
module tb_snake_position_updater;

    logic        clk;
    logic        reset;
    logic        tick;
    logic [1:0]  direction;
    logic [11:0] apple_pos;
    logic [5:0]  value_addr;
    logic [11:0] cur_tail_pos;
    logic [11:0] snake_head_pos;
    logic [5:0]  num_tails;
    logic        calculation_finished;
    logic        apple_eaten;
    logic        game_over;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    snake_position_updater dut (
        .clk                  (clk),
        .reset                (reset),
        .tick                 (tick),
        .direction            (direction),
        .apple_pos            (apple_pos),
        .value_addr           (value_addr),
        .cur_tail_pos         (cur_tail_pos),
        .snake_head_pos       (snake_head_pos),
        .num_tails            (num_tails),
        .calculation_finished (calculation_finished),
        .apple_eaten          (apple_eaten),
        .game_over            (game_over),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rd(input int addr, input int exp, input string tag);
        value_addr = 6'(addr);
        #1;
        chk(tag, 32'(cur_tail_pos), 32'(exp));
    endtask

    task automatic step(input logic [1:0] dir, input int exp_lat,
                        input int exp_head, input logic exp_eat,
                        input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        direction = dir;
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (calculation_finished) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_head"}, 32'(snake_head_pos), 32'(exp_head));
        chk({tag, "_eaten"}, 32'(apple_eaten), 32'(exp_eat));
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, 32'(calculation_finished), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        int busy_cnt;
        reset      = 1'b1;
        tick       = 1'b0;
        direction  = 2'b01;
        apple_pos  = 12'd4095;
        value_addr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_head", 32'(snake_head_pos), 32'd620);
        chk("rst_num", 32'(num_tails), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_done", 32'(calculation_finished), 32'd0);
        chk("rst_eaten", 32'(apple_eaten), 32'd0);
        rd(0, 0, "rst_tail0");

        step(2'b01, 3, 621, 1'b0, "n0_right");
        chk("n0_num", 32'(num_tails), 32'd0);
        step(2'b11, 3, 620, 1'b0, "n0_reverse_ok");
        step(2'b01, 3, 621, 1'b0, "n0_back_right");

        for (int i = 0; i < 18; i++)
            step(2'b01, 3, 622 + i, 1'b0, "walk_right");
        step(2'b01, 3, 600, 1'b0, "wrap_x");
        for (int i = 1; i <= 15; i++)
            step(2'b00, 3, 600 - 40 * i, 1'b0, "walk_up");
        step(2'b00, 3, 1160, 1'b0, "wrap_y");

        do_reset();
        apple_pos = 12'd621;
        step(2'b01, 3, 621, 1'b1, "eat1");
        chk("eat1_num", 32'(num_tails), 32'd1);
        rd(0, 620, "eat1_tail0");
        apple_pos = 12'd4095;
        step(2'b11, 4, 622, 1'b0, "n1_reverse_blocked");
        chk("n1_num", 32'(num_tails), 32'd1);
        rd(0, 621, "n1_tail0");

        do_reset();
        apple_pos = 12'd621;
        step(2'b01, 3, 621, 1'b1, "grow1");
        apple_pos = 12'd622;
        step(2'b01, 4, 622, 1'b1, "grow2");
        apple_pos = 12'd623;
        step(2'b01, 6, 623, 1'b1, "grow3");
        apple_pos = 12'd624;
        step(2'b01, 8, 624, 1'b1, "grow4");
        chk("len4_num", 32'(num_tails), 32'd4);
        rd(0, 623, "len4_t0");
        rd(1, 622, "len4_t1");
        rd(2, 621, "len4_t2");
        rd(3, 620, "len4_t3");
        rd(32, 0, "addr32_zero");
        rd(40, 0, "addr40_zero");
        apple_pos = 12'd4095;
        step(2'b00, 10, 584, 1'b0, "steer_up");
        chk("steer_up_over", 32'(game_over), 32'd0);
        step(2'b11, 10, 583, 1'b0, "steer_left");
        chk("steer_left_over", 32'(game_over), 32'd0);
        step(2'b10, 10, 623, 1'b0, "steer_down_hit");
        chk("hit_over", 32'(game_over), 32'd1);
        chk("hit_num", 32'(num_tails), 32'd4);

        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        pulses   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (calculation_finished) pulses++;
        end
        chk("over_tick_busy", 32'(busy_cnt), 32'd0);
        chk("over_tick_pulse", 32'(pulses), 32'd0);
        chk("over_sticky", 32'(game_over), 32'd1);
        chk("over_head", 32'(snake_head_pos), 32'd623);
        do_reset();
        #1;
        chk("over_cleared", 32'(game_over), 32'd0);
        chk("over_rst_head", 32'(snake_head_pos), 32'd620);

        @(negedge clk);
        direction = 2'b01;
        tick      = 1'b1;
        pulses    = 0;
        busy_cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (calculation_finished) begin
                pulses++;
                tick = 1'b0;
            end
        end
        tick = 1'b0;
        chk("hold_pulses", 32'(pulses), 32'd1);
        chk("hold_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("hold_head", 32'(snake_head_pos), 32'd621);

        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_head", 32'(snake_head_pos), 32'd620);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (calculation_finished) pulses++;
        end
        chk("mid_rst_no_pulse", 32'(pulses), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
